// File: rtl/ram_tdp_clear.sv
// True-dual-port RAM with write-collision flag and a clear sequencer
// that fills every word with ClearValue after reset or on request.
module ram_tdp_clear #(
   parameter int unsigned         AddrSize   = 4,
   parameter int unsigned         DataSize   = 8,
   parameter bit                  Registered = 1'b1,
   parameter logic [DataSize-1:0] ClearValue = '0
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                clear,
   output logic                busy,
   input  logic                we0,
   input  logic [AddrSize-1:0] addr0,
   input  logic [DataSize-1:0] data_i0,
   output logic [DataSize-1:0] data_o0,
   input  logic                we1,
   input  logic [AddrSize-1:0] addr1,
   input  logic [DataSize-1:0] data_i1,
   output logic [DataSize-1:0] data_o1,
   output logic                collision
);

   localparam int unsigned Depth = 1 << AddrSize;

   typedef enum logic {
      CLEAR,
      READY
   } state_e;

   state_e              state_q, state_d;
   logic [AddrSize-1:0] cnt_q, cnt_d;
   logic                coll_q, coll_d;
   logic                hit;
   logic [DataSize-1:0] mem_q [Depth];

   assign busy      = (state_q == CLEAR);
   assign hit       = we0 & we1 & (addr0 == addr1);
   assign coll_d    = ~busy & hit;
   assign collision = coll_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         CLEAR: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == '1) state_d = READY;
         end
         READY: begin
            if (clear) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
         default: state_d = CLEAR;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= CLEAR;
         cnt_q   <= '0;
         coll_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         coll_q  <= coll_d;
      end
   end

   // Array is deliberately unreset; the sequencer initialises it.
   // On a same-address collision port 0 wins.
   always_ff @(posedge clock) begin
      if (busy) begin
         mem_q[cnt_q] <= ClearValue;
      end else begin
         if (we1 && !hit) mem_q[addr1] <= data_i1;
         if (we0)         mem_q[addr0] <= data_i0;
      end
   end

   if (Registered) begin : g_reg
      logic [DataSize-1:0] rd0_q, rd1_q;

      always_ff @(posedge clock or negedge reset) begin
         if (!reset) begin
            rd0_q <= '0;
            rd1_q <= '0;
         end else if (busy) begin
            rd0_q <= '0;
            rd1_q <= '0;
         end else begin
            rd0_q <= mem_q[addr0];
            rd1_q <= mem_q[addr1];
         end
      end

      assign data_o0 = rd0_q;
      assign data_o1 = rd1_q;
   end else begin : g_comb
      assign data_o0 = mem_q[addr0];
      assign data_o1 = mem_q[addr1];
   end

endmodule

// File: doc/ram_tdp_clear.md
Name: ram_tdp_clear

Overview:
Parametrised true-dual-port RAM, the successor to the team's single-write/dual-read RAM. It has two independent read/write ports, selectable registered or combinational read, and write-collision detection. A built-in clear sequencer initialises every location after reset or on request. It is used as shared scratch storage between two datapath clients that both need write access.

Parameters:
AddrSize, 4, address width; depth = 2^AddrSize.
DataSize, 8, word width.
Registered, 1, 1 = synchronous read with 1-cycle latency; 0 = combinational (asynchronous) read.
ClearValue, 0, DataSize-wide value written to every location by the clear sequencer.

Ports:
clock  in  1  system clock, rising-edge.
reset  in  1  asynchronous, active-low reset.
clear  in  1  synchronous request to re-run the clear sequence.
busy  out  1  high while the clear sequence runs; writes are ignored.
we0  in  1  port 0 write enable.
addr0  in  AddrSize  port 0 address (read and write).
data_i0  in  DataSize  port 0 write data.
data_o0  out  DataSize  port 0 read data.
we1  in  1  port 1 write enable.
addr1  in  AddrSize  port 1 address.
data_i1  in  DataSize  port 1 write data.
data_o1  out  DataSize  port 1 read data.
collision  out  1  one-cycle pulse: both ports wrote the same address.

Behaviour:
- Reset (reset=0), asynchronous:
  - FSM goes to CLEAR; clear counter = 0.
  - busy = 1, collision = 0.
  - Registered read registers = 0.
  - The memory array is not reset directly.
- FSM states:
  - CLEAR: each rising edge writes ClearValue to mem[counter], then counter increments. On the edge that writes address 2^AddrSize-1, go to READY. busy goes low after exactly 2^AddrSize clock edges with reset=1.
  - READY: clear=1 at a rising edge sends the FSM to CLEAR with counter = 0. busy=1 from the next cycle.
- clear while already in CLEAR: ignored. The sequence is not restarted.
- Reset asserted mid-clear: sequence restarts from address 0 after release. Full 2^AddrSize cycles again.
- While busy:
  - we0/we1 are ignored.
  - Registered=1: data_o0/data_o1 registers load 0.
  - Registered=0: data_o0/data_o1 show the array contents.
  - collision stays 0.
- Writes (READY): on a rising edge with weN=1, mem[addrN] <= data_iN. Both ports may write different addresses in the same cycle.
- Collision: we0=we1=1 and addr0==addr1 at an edge:
  - Port 0 data is stored; port 1 is discarded.
  - collision=1 for the following cycle only (registered).
- Read, Registered=1:
  - data_oN <= mem[addrN] at each edge, read-first: the old contents are returned when that port or the other port writes the same address on the same edge.
  - New data is visible one cycle later.
- Read, Registered=0:
  - data_oN = mem[addrN] combinationally.
  - Reflects a write immediately after the writing edge.
- Counter and addresses are AddrSize wide. No out-of-range addresses exist.

Test Plan:
1. Release reset with AddrSize=4, ClearValue=0x5A -> busy high for exactly 16 rising edges, then 0. Sweeping addr0/addr1 over 0..15 returns 0x5A on both ports.
2. READY, Registered=1: we0=1 addr0=0xA data_i0=0xBB and we1=1 addr1=0x2 data_i1=0xAA in the same cycle. Next cycle read addr0=0x2, addr1=0xA -> one edge later data_o0=0xAA, data_o1=0xBB.
3. we0=we1=1, addr0=addr1=0x7, data_i0=0x11, data_i1=0x22 -> collision=1 for exactly one cycle. A subsequent read of 0x7 returns 0x11 on both ports.
4. mem[1]=0xAE; port 0 writes 0xEF to 0x1 while port 1 reads 0x1 on the same edge -> data_o1=0xAE after that edge, 0xEF after the next. With Registered=0, data_o1=0xEF right after the writing edge.
5. Fill several locations, pulse clear for one cycle -> busy=1 for 16 cycles. Writes to 0x3 during busy are dropped. Afterwards every location reads ClearValue and collision never pulsed.
6. Assert reset after 5 clear cycles -> busy=1, data_o0=data_o1=0 immediately, without waiting for a clock. After release, busy stays high for a full 16 cycles.
